// File: rtl/mode_alu_stream_pkg.sv
// Shared types and default sizing for the mode ALU stream slice.
package mode_alu_pkg;

   typedef enum logic [1:0] {
      MODE_ADD     = 2'd0,
      MODE_MUL     = 2'd1,
      MODE_ABSDIFF = 2'd2,
      MODE_MAC     = 2'd3
   } mode_e;

   localparam int unsigned DEF_WIDTH = 4;
   localparam int unsigned DEF_DEPTH = 8;
   localparam int unsigned RES_W     = 2 * DEF_WIDTH;

endpackage

// File: rtl/mode_alu_stream_if.sv
// Operand/result stream bundle: producer side (in_*) and consumer side (out*).
interface mode_alu_stream_if
   import mode_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) ();

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   mode_e              mode;
   logic               clr_acc;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out;

   // Traffic generator / consumer side
   modport master (
      output in_valid, in_a, in_b, mode, clr_acc, out_ready,
      input  in_ready, out_valid, out
   );

   // Compute unit side
   modport slave (
      input  in_valid, in_a, in_b, mode, clr_acc, out_ready,
      output in_ready, out_valid, out
   );

endinterface

// File: rtl/mode_alu_stream_fifo.sv
// Synchronous result FIFO; push is refused when full regardless of a same-cycle pop.
module result_fifo #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [DW-1:0]              din_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [DW-1:0]              head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          wr_en, rd_en;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign wr_en   = push_i & ~full_o;
   assign rd_en   = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Next pointers and occupancy; power-of-2 depth lets pointers wrap naturally
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
      if (wr_en && !rd_en) count_d = count_q + CW'(1);
      else if (rd_en && !wr_en) count_d = count_q - CW'(1);
   end

   // Pointer and count state, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/mode_alu_stream.sv
// Mode ALU stream: ADD/MUL/ABSDIFF/MAC on operand beats, results queued in a FIFO.
module mode_alu_stream
   import mode_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   mode_alu_stream_if.slave  bus
);

   localparam int unsigned RW = 2 * WIDTH;

   logic [RW-1:0]    acc_q, acc_d;
   logic [RW-1:0]    acc_base;
   logic [RW-1:0]    prod;
   logic [RW-1:0]    result;
   logic [WIDTH-1:0] diff;
   logic             accept;
   logic             fifo_full, fifo_empty;
   logic [RW-1:0]    fifo_head;
   logic [$clog2(DEPTH+1)-1:0] fifo_count;

   assign accept   = bus.in_valid & ~fifo_full;
   assign prod     = RW'(bus.in_a) * RW'(bus.in_b);
   assign diff     = (bus.in_a >= bus.in_b) ? (bus.in_a - bus.in_b) : (bus.in_b - bus.in_a);
   // A same-edge clear takes effect before the MAC add
   assign acc_base = bus.clr_acc ? '0 : acc_q;

   // Result select for the current beat
   always_comb begin
      result = '0;
      unique case (bus.mode)
         MODE_ADD:     result = RW'(bus.in_a) + RW'(bus.in_b);
         MODE_MUL:     result = prod;
         MODE_ABSDIFF: result = RW'(diff);
         MODE_MAC:     result = acc_base + prod;
         default:      result = '0;
      endcase
   end

   // Accumulator moves only on an accepted MAC beat or a clear
   always_comb begin
      acc_d = acc_q;
      if (accept && bus.mode == MODE_MAC) acc_d = acc_base + prod;
      else if (bus.clr_acc)               acc_d = '0;
   end

   // Accumulator register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;
   end

   result_fifo #(
      .DW    (RW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (accept),
      .pop_i   (bus.out_ready),
      .din_i   (result),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head),
      .count_o (fifo_count)
   );

   assign bus.in_ready  = ~fifo_full;
   assign bus.out_valid = ~fifo_empty;
   assign bus.out       = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_mode_alu_stream.sv
// Directed self-checking bench for mode_alu_stream (WIDTH=4, DEPTH=8).
module tb_mode_alu_stream;
   import mode_alu_pkg::*;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   mode_alu_stream_if #(.WIDTH(4)) bus ();

   mode_alu_stream #(.WIDTH(4), .DEPTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic drive(input mode_e m, input logic [3:0] a, input logic [3:0] b, input logic clr);
      bus.in_valid = 1'b1;
      bus.mode     = m;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.clr_acc  = clr;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.clr_acc  = 1'b0;
   endtask

   initial begin
      n_pass       = 0;
      n_total      = 0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
      bus.mode     = MODE_ADD;
      bus.clr_acc  = 1'b0;
      bus.out_ready = 1'b0;

      // 1. reset state
      repeat (3) tick();
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out", 32'(bus.out), 32'h00);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      rst_n = 1'b1;
      tick();

      // async reset mid-cycle with a buffered result
      drive(MODE_ADD, 4'd1, 4'd2, 1'b0);
      tick();
      idle();
      check("pre_async_out", 32'(bus.out), 32'h03);
      #2 rst_n = 1'b0;
      #1;
      check("async_out_valid", 32'(bus.out_valid), 32'd0);
      check("async_out", 32'(bus.out), 32'h00);
      check("async_in_ready", 32'(bus.in_ready), 32'd1);
      #1 rst_n = 1'b1;
      tick();

      // 2. back-to-back ADD/MUL/ABSDIFF
      bus.out_ready = 1'b1;
      drive(MODE_ADD, 4'hF, 4'hF, 1'b0);
      tick();
      check("add_ff", 32'(bus.out), 32'h1E);
      check("add_valid", 32'(bus.out_valid), 32'd1);
      drive(MODE_MUL, 4'hF, 4'hF, 1'b0);
      tick();
      check("mul_ff", 32'(bus.out), 32'hE1);
      drive(MODE_ABSDIFF, 4'h3, 4'h9, 1'b0);
      tick();
      check("absdiff_39", 32'(bus.out), 32'h06);
      idle();
      tick();
      check("drained_valid", 32'(bus.out_valid), 32'd0);

      // 3. MAC sequence and clears
      drive(MODE_MAC, 4'd2, 4'd3, 1'b0);
      tick();
      check("mac_2_3", 32'(bus.out), 32'd6);
      drive(MODE_MAC, 4'd4, 4'd5, 1'b0);
      tick();
      check("mac_4_5", 32'(bus.out), 32'd26);
      drive(MODE_ADD, 4'd1, 4'd1, 1'b0);
      tick();
      check("add_keeps_acc", 32'(bus.out), 32'd2);
      drive(MODE_MAC, 4'd1, 4'd1, 1'b0);
      tick();
      check("mac_1_1", 32'(bus.out), 32'd27);
      drive(MODE_MAC, 4'd3, 4'd3, 1'b1);
      tick();
      check("clr_with_mac", 32'(bus.out), 32'd9);
      idle();
      bus.clr_acc = 1'b1;
      tick();
      drive(MODE_MAC, 4'd1, 4'd2, 1'b0);
      tick();
      check("clr_alone_mac", 32'(bus.out), 32'd2);

      // 4. wrap: acc = 100 + 150 = 250, then +9
      drive(MODE_MAC, 4'd10, 4'd10, 1'b1);
      tick();
      check("wrap_100", 32'(bus.out), 32'h64);
      drive(MODE_MAC, 4'd10, 4'd15, 1'b0);
      tick();
      check("wrap_250", 32'(bus.out), 32'hFA);
      drive(MODE_MAC, 4'd3, 4'd3, 1'b0);
      tick();
      check("wrap_259", 32'(bus.out), 32'h03);
      idle();
      tick();

      // 5. fill to full, drop overflow beats, drain in order
      bus.out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(MODE_ADD, 4'(i), 4'd0, 1'b0);
         tick();
         check($sformatf("fill_in_ready_%0d", i), 32'(bus.in_ready), (i < 7) ? 32'd1 : 32'd0);
      end
      idle();
      check("full_count", 32'(dut.u_fifo.count_o), 32'd8);
      bus.out_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         check($sformatf("drain_%0d", j), 32'(bus.out), 32'(j));
         tick();
      end
      check("drain_empty", 32'(bus.out_valid), 32'd0);

      // push+pop at count 4
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(MODE_ADD, 4'(i), 4'd1, 1'b0);
         tick();
      end
      check("count_4", 32'(dut.u_fifo.count_o), 32'd4);
      bus.out_ready = 1'b1;
      drive(MODE_ADD, 4'd5, 4'd5, 1'b0);
      tick();
      idle();
      check("pushpop_count", 32'(dut.u_fifo.count_o), 32'd4);
      check("pushpop_head", 32'(bus.out), 32'd2);
      repeat (4) tick();
      check("pushpop_drained", 32'(bus.out_valid), 32'd0);

      // 6. reset with 5 buffered results and acc = 26
      bus.out_ready = 1'b0;
      drive(MODE_MAC, 4'd2, 4'd3, 1'b1);
      tick();
      drive(MODE_MAC, 4'd4, 4'd5, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(MODE_ADD, 4'(i), 4'd0, 1'b0);
         tick();
      end
      idle();
      check("buf5_count", 32'(dut.u_fifo.count_o), 32'd5);
      check("buf5_head", 32'(bus.out), 32'd6);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      #1 rst_n = 1'b1;
      tick();
      bus.out_ready = 1'b1;
      drive(MODE_MAC, 4'd1, 4'd1, 1'b0);
      tick();
      idle();
      check("post_rst_mac", 32'(bus.out), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
